iter_mdu: RTL and testbench

Parametrised iterative multiply/divide unit holding architectural HI/LO registers, the multi-cycle companion to the combinational ALU in the execute stage. Accepts one operation per `Start` pulse, computes one bit per clock (shift-add multiply, restoring divide), and reports progress on `Busy` so the pipeline can stall HI/LO consumers. Width is a parameter, so the same block serves the 32-bit datapath and narrow test instances.

---
 rtl/mdu_pkg.sv | 18 +
 rtl/mdu_sign_fix.sv | 42 ++++
 rtl/iter_mdu.sv | 133 +++++++++++++
 tb/tb_iter_mdu.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared MDOp encoding and FSM state type for the iterative
// multiply/divide unit, its execute-stage decoder and the stall controller.
package mdu_pkg;

  localparam logic [2:0] MDU_NOP   = 3'b000;
  localparam logic [2:0] MDU_MULTU = 3'b001;
  localparam logic [2:0] MDU_MULT  = 3'b010;
  localparam logic [2:0] MDU_DIVU  = 3'b011;
  localparam logic [2:0] MDU_DIV   = 3'b100;
  localparam logic [2:0] MDU_MTHI  = 3'b101;
  localparam logic [2:0] MDU_MTLO  = 3'b110;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } mdu_state_e;

endpackage

// File: rtl/mdu_sign_fix.sv
// mdu_sign_fix: combinational final-result correction for iter_mdu.
//   is_div_i  : 1 = divide result, 0 = multiply product
//   neg_lo_i  : negate product (mul) / quotient (div)
//   neg_hi_i  : negate remainder (div only)
//   dz_i      : divide by zero -> quotient forced to all ones
//   hi_mag_i, lo_mag_i : magnitude {hi,lo} product or {remainder,quotient}
//   hi_o, lo_o         : values written to HI/LO
module mdu_sign_fix
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             is_div_i,
  input  logic             neg_lo_i,
  input  logic             neg_hi_i,
  input  logic             dz_i,
  input  logic [WIDTH-1:0] hi_mag_i,
  input  logic [WIDTH-1:0] lo_mag_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  logic [2*WIDTH-1:0] prod, prod_f;
  logic [WIDTH-1:0]   rem_f, quo_f;

  always_comb begin
    prod   = {hi_mag_i, lo_mag_i};
    prod_f = neg_lo_i ? -prod : prod;
    // With a zero divisor the iteration leaves |A| in the remainder, so
    // restoring A's sign reproduces A exactly (most-negative included).
    rem_f  = neg_hi_i ? -hi_mag_i : hi_mag_i;
    quo_f  = dz_i ? '1 : (neg_lo_i ? -lo_mag_i : lo_mag_i);
    if (is_div_i) begin
      hi_o = rem_f;
      lo_o = quo_f;
    end else begin
      hi_o = prod_f[2*WIDTH-1:WIDTH];
      lo_o = prod_f[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/iter_mdu.sv
// iter_mdu: iterative multiply/divide unit with architectural HI/LO.
// One bit per clock: shift-add multiply, restoring divide; WIDTH cycles.
//   clk, reset (async, active high)
//   Start, MDOp, A, B : request, sampled at a rising edge while idle
//   Busy              : iteration in progress (HI/LO stable meanwhile)
//   HI, LO            : high product/remainder, low product/quotient
module iter_mdu
  import mdu_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH+1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic [2:0]       MDOp,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  mdu_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q, div_q, neg_lo_q, neg_hi_q, dz_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  // acc_q: product high half / partial remainder
  // sh_q : multiplier being consumed / dividend shifting into quotient
  // opd_q: multiplicand / divisor magnitude
  logic [WIDTH-1:0] acc_q, sh_q, opd_q;

  // request decode
  logic             is_mul, is_div, sgn, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  always_comb begin
    is_mul = (MDOp == MDU_MULTU) || (MDOp == MDU_MULT);
    is_div = (MDOp == MDU_DIVU)  || (MDOp == MDU_DIV);
    sgn    = (MDOp == MDU_MULT)  || (MDOp == MDU_DIV);
    a_neg  = sgn & A[WIDTH-1];
    b_neg  = sgn & B[WIDTH-1];
    a_mag  = a_neg ? -A : A;
    b_mag  = b_neg ? -B : B;
  end

  // one iteration of each algorithm
  logic [WIDTH:0]   mul_sum, div_r, div_s;
  logic             div_ge;
  logic [WIDTH-1:0] acc_d, sh_d, hi_fix, lo_fix;

  always_comb begin
    mul_sum = {1'b0, acc_q} + (sh_q[0] ? {1'b0, opd_q} : '0);
    div_r   = {acc_q, sh_q[WIDTH-1]};
    div_ge  = div_r >= {1'b0, opd_q};
    div_s   = div_ge ? div_r - {1'b0, opd_q} : div_r;
    if (div_q) begin
      acc_d = div_s[WIDTH-1:0];  // remainder < divisor, fits WIDTH bits
      sh_d  = {sh_q[WIDTH-2:0], div_ge};
    end else begin
      acc_d = mul_sum[WIDTH:1];
      sh_d  = {mul_sum[0], sh_q[WIDTH-1:1]};
    end
  end

  mdu_sign_fix #(.WIDTH(WIDTH)) u_fix (
    .is_div_i (div_q),
    .neg_lo_i (neg_lo_q),
    .neg_hi_i (neg_hi_q),
    .dz_i     (dz_q),
    .hi_mag_i (acc_d),
    .lo_mag_i (sh_d),
    .hi_o     (hi_fix),
    .lo_o     (lo_fix)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      acc_q    <= '0;
      sh_q     <= '0;
      opd_q    <= '0;
      div_q    <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (Start) begin
            if (is_mul || is_div) begin
              acc_q    <= '0;
              sh_q     <= is_div ? a_mag : b_mag;
              opd_q    <= is_div ? b_mag : a_mag;
              div_q    <= is_div;
              neg_lo_q <= a_neg ^ b_neg;
              neg_hi_q <= is_div & a_neg;
              dz_q     <= is_div & (B == '0);
              cnt_q    <= CNT_W'(WIDTH);
              busy_q   <= 1'b1;
              state_q  <= S_RUN;
            end else if (MDOp == MDU_MTHI) begin
              hi_q <= A;
            end else if (MDOp == MDU_MTLO) begin
              lo_q <= A;
            end
          end
        end
        S_RUN: begin
          acc_q <= acc_d;
          sh_q  <= sh_d;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            hi_q    <= hi_fix;
            lo_q    <= lo_fix;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign Busy = busy_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_iter_mdu.sv
module tb_iter_mdu;
  import mdu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 32-bit instance
  logic        reset, start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy;
  logic [31:0] hi, lo;

  // 8-bit instance
  logic        reset8, start8;
  logic [2:0]  op8;
  logic [7:0]  a8, b8;
  logic        busy8;
  logic [7:0]  hi8, lo8;

  iter_mdu #(.WIDTH(32)) u_dut (
    .clk(clk), .reset(reset), .Start(start), .MDOp(op), .A(a), .B(b),
    .Busy(busy), .HI(hi), .LO(lo)
  );

  iter_mdu #(.WIDTH(8)) u_dut8 (
    .clk(clk), .reset(reset8), .Start(start8), .MDOp(op8), .A(a8), .B(b8),
    .Busy(busy8), .HI(hi8), .LO(lo8)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Issue one op on the 32-bit unit; returns busy cycle count and whether
  // HI/LO stayed at their pre-op values throughout.
  task automatic run32(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       output int cyc, output bit held);
    logic [31:0] h0, l0;
    @(negedge clk);
    h0 = hi; l0 = lo;
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0; held = 1'b1;
    while (busy && cyc < 100) begin
      cyc++;
      if (hi !== h0 || lo !== l0) held = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  task automatic run8(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                      output int cyc);
    @(negedge clk);
    op8 = o; a8 = x; b8 = y; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    cyc = 0;
    while (busy8 && cyc < 100) begin
      cyc++;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int  cyc;
    bit  held;

    reset = 1'b1; start = 1'b0; op = MDU_NOP; a = '0; b = '0;
    reset8 = 1'b1; start8 = 1'b0; op8 = MDU_NOP; a8 = '0; b8 = '0;
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst8_busy", busy8, 0);
    @(negedge clk);
    reset = 1'b0; reset8 = 1'b0;

    // MULTU 7*4
    run32(MDU_MULTU, 32'd7, 32'd4, cyc, held);
    chk("multu_cyc", cyc, 32);
    chk("multu_hi", hi, 32'h0);
    chk("multu_lo", lo, 32'h1C);

    // MULT -3*5, HI/LO held while busy
    run32(MDU_MULT, 32'hFFFF_FFFD, 32'd5, cyc, held);
    chk("mult_cyc", cyc, 32);
    chk("mult_held", held, 1);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFF1);

    // DIV -7/2 -> q=-3, r=-1
    run32(MDU_DIV, 32'hFFFF_FFF9, 32'd2, cyc, held);
    chk("div_cyc", cyc, 32);
    chk("div_held", held, 1);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFF);

    // DIVU by zero
    run32(MDU_DIVU, 32'd7, 32'd0, cyc, held);
    chk("dz_cyc", cyc, 32);
    chk("dz_hi", hi, 32'h7);
    chk("dz_lo", lo, 32'hFFFF_FFFF);

    // DIV signed by zero: HI returns A unchanged
    run32(MDU_DIV, 32'hFFFF_FFF9, 32'd0, cyc, held);
    chk("sdz_hi", hi, 32'hFFFF_FFF9);
    chk("sdz_lo", lo, 32'hFFFF_FFFF);

    // DIV most-negative by -1 wraps
    run32(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, cyc, held);
    chk("ovf_lo", lo, 32'h8000_0000);
    chk("ovf_hi", hi, 32'h0);

    // MULTU 0x10000*0x10 with MTHI pulsed mid-run (must be ignored)
    @(negedge clk);
    op = MDU_MULTU; a = 32'h0001_0000; b = 32'h10; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    op = MDU_MTHI; a = 32'h1234; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("mid_busy", busy, 1);
    chk("mid_hi", hi, 32'h0);
    cyc = 0;
    while (busy && cyc < 100) begin
      cyc++;
      @(posedge clk); #1;
    end
    chk("mid_done", busy, 0);
    chk("mid_fin_hi", hi, 32'h0);
    chk("mid_fin_lo", lo, 32'h0010_0000);
    repeat (2) @(posedge clk);
    #1;
    chk("mid_noq_hi", hi, 32'h0);
    chk("mid_noq_busy", busy, 0);

    // MTLO from idle
    @(negedge clk);
    op = MDU_MTLO; a = 32'hABCD; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("mtlo_lo", lo, 32'hABCD);
    chk("mtlo_busy", busy, 0);

    // MTHI from idle, then reset during a DIV
    @(negedge clk);
    op = MDU_MTHI; a = 32'h5555; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("mthi_hi", hi, 32'h5555);
    @(negedge clk);
    op = MDU_DIV; a = 32'd100; b = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_hi", hi, 0);
    chk("abort_lo", lo, 0);
    @(negedge clk);
    reset = 1'b0;
    run32(MDU_MULTU, 32'd3, 32'd3, cyc, held);
    chk("post_cyc", cyc, 32);
    chk("post_lo", lo, 32'd9);
    chk("post_hi", hi, 32'd0);

    // 8-bit instance
    run8(MDU_DIV, 8'h80, 8'hFF, cyc);
    chk("w8_div_cyc", cyc, 8);
    chk("w8_div_lo", lo8, 8'h80);
    chk("w8_div_hi", hi8, 8'h00);
    run8(MDU_MULTU, 8'hFF, 8'hFF, cyc);
    chk("w8_multu_cyc", cyc, 8);
    chk("w8_multu", {hi8, lo8}, 16'hFE01);
    run8(MDU_MULT, 8'hFF, 8'hFF, cyc);
    chk("w8_mult", {hi8, lo8}, 16'h0001);
    run8(MDU_DIVU, 8'd200, 8'd7, cyc);
    chk("w8_divu", {hi8, lo8}, {8'd4, 8'd28});
    run8(MDU_DIV, 8'd7, 8'hFE, cyc);   // 7 / -2 -> q=-3, r=1
    chk("w8_div_pn", {hi8, lo8}, {8'h01, 8'hFD});

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
